// File: rtl/vstore_unit.sv
// Vector store unit: slices one wide store request into memory write beats
// with byte strobes and retires it with a done/err pulse.
module vstore_unit #(
    parameter int VEC_W  = 512,
    parameter int MEM_W  = 128,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [1:0]           req_len,
    input  logic [VEC_W-1:0]     req_data,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [MEM_W-1:0]     mem_wdata,
    output logic [MEM_W/8-1:0]   mem_wstrb,
    output logic                 done,
    output logic                 err
);

    localparam int SB   = MEM_W / 8;
    localparam int LB   = $clog2(SB);
    localparam int NB   = VEC_W / MEM_W;
    localparam int N128 = (128 / MEM_W > 0) ? 128 / MEM_W : 1;
    localparam int CW   = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [VEC_W-1:0]  data_q, data_d;
    logic [SB-1:0]     strb_q, strb_d;
    logic              err_q, err_d;

    int   lane;
    logic illegal;

    // 32-bit stores land in the 32-bit lane of the beat selected by addr
    assign lane = int'(req_addr[LB-1:0]) >> 2;

    always_comb begin
        illegal = 1'b0;
        unique case (req_len)
            2'd0:    illegal = (req_addr[1:0] != 2'b00);
            2'd1,
            2'd2:    illegal = (req_addr[LB-1:0] != '0);
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        base_d  = base_q;
        data_d  = data_q;
        strb_d  = strb_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SEND;
                        cnt_d   = '0;
                        base_d  = {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                        if (req_len == 2'd0) begin
                            data_d = VEC_W'(req_data[31:0]) << (lane * 32);
                            strb_d = SB'(4'hF) << (lane * 4);
                            last_d = '0;
                        end else begin
                            data_d = req_data;
                            strb_d = '1;
                            last_d = (req_len == 2'd1) ? CW'(N128 - 1)
                                                       : CW'(NB - 1);
                        end
                    end
                end
            end
            S_SEND: begin
                if (mem_wready) begin
                    if (cnt_q == last_q) state_d = S_RESP;
                    else                 cnt_d   = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            base_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            base_q  <= base_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_wdata = '0;
        for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) mem_wdata = data_q[k*MEM_W +: MEM_W];
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign mem_wvalid = (state_q == S_SEND);
    assign mem_waddr  = base_q + (ADDR_W'(cnt_q) << LB);
    assign mem_wstrb  = mem_wvalid ? strb_q : '0;
    assign done       = (state_q == S_RESP);
    assign err        = done && err_q;

endmodule

// File: tb/tb_vstore_unit.sv
// Self-checking bench for vstore_unit: scoreboard of expected write beats
// filled when a request is driven and drained as beats handshake.
module tb_vstore_unit;

    localparam int VEC_W  = 512;
    localparam int MEM_W  = 128;
    localparam int ADDR_W = 32;

    logic               clk;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [1:0]         req_len;
    logic [VEC_W-1:0]   req_data;
    logic               mem_wvalid;
    logic               mem_wready;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [MEM_W-1:0]   mem_wdata;
    logic [MEM_W/8-1:0] mem_wstrb;
    logic               done;
    logic               err;

    vstore_unit #(.VEC_W(VEC_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  a;
        logic [127:0] d;
        logic [15:0]  s;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats, derived from the request alone
    task automatic push_store(input logic [31:0] a, input logic [1:0] l,
                              input logic [511:0] d);
        beat_t b;
        int lane;
        if (l == 2'd3) return;
        if (l == 2'd0) begin
            if (a[1:0] != 2'b00) return;
            lane = int'(a[3:2]);
            b.a = a & 32'hFFFF_FFF0;
            b.d = {96'h0, d[31:0]} << (32 * lane);
            b.s = 16'h000F << (4 * lane);
            exp_q.push_back(b);
            return;
        end
        if (a[3:0] != 4'h0) return;
        for (int k = 0; k < ((l == 2'd1) ? 1 : 4); k++) begin
            b.a = a + 32'(16 * k);
            b.d = d[128*k +: 128];
            b.s = 16'hFFFF;
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [1:0] l,
                             input logic [511:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_data  = d;
        push_store(a, l, d);
    endtask

    // Runs cycles after acceptance until done; c counts cycles from accept
    task automatic pump(input bit hold, input bit stall, output int nb,
                        output int nv, output int dc, output logic ev);
        logic [31:0]  pa;
        logic [127:0] pd;
        logic [15:0]  ps;
        bit pv;
        beat_t e;
        nb = 0; nv = 0; dc = -1; ev = 1'bx; pv = 0;
        pa = '0; pd = '0; ps = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            n_checks++;
            if (req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready c=%0d got %b want 0", c, req_ready);
            end
            if (mem_wvalid === 1'b1) nv++;
            if (pv) begin
                n_checks++;
                if (mem_wvalid !== 1'b1 || mem_waddr !== pa ||
                    mem_wdata !== pd || mem_wstrb !== ps) begin
                    n_fail++;
                    $display("FAIL stall_stable c=%0d got v=%b a=%h s=%h want v=1 a=%h s=%h",
                             c, mem_wvalid, mem_waddr, mem_wstrb, pa, ps);
                end
            end
            if (done === 1'b1) begin
                dc = c;
                ev = err;
                break;
            end
            mem_wready = stall ? (c % 3 == 1) : 1'b1;
            pv = 0;
            if (mem_wvalid === 1'b1) begin
                if (mem_wready) begin
                    nb++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_beat c=%0d got a=%h want none", c, mem_waddr);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_waddr !== e.a || mem_wdata !== e.d ||
                            mem_wstrb !== e.s) begin
                            n_fail++;
                            $display("FAIL beat c=%0d got a=%h d=%h s=%h want a=%h d=%h s=%h",
                                     c, mem_waddr, mem_wdata, mem_wstrb, e.a, e.d, e.s);
                        end
                    end
                end else begin
                    pv = 1;
                    pa = mem_waddr;
                    pd = mem_wdata;
                    ps = mem_wstrb;
                end
            end
        end
        if (dc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout got none want done within 40 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        req_data = '0; mem_wready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || mem_wvalid !== 1'b0 || mem_waddr !== '0 ||
            mem_wdata !== '0 || mem_wstrb !== '0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b v=%b a=%h s=%h done=%b err=%b want all 0",
                     req_ready, mem_wvalid, mem_waddr, mem_wstrb, done, err);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_len2_burst();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        drive_req(32'h100, 2'd2, d);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len2_ready got %b want 1", req_ready);
        end
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 4 || dc != 5 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len2_burst got beats=%0d done_cyc=%0d err=%b left=%0d want 4 5 0 0",
                     nb, dc, ev, exp_q.size());
        end
    endtask

    task automatic test_len0_lane();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        d = '1;
        d[31:0] = 32'hDEADBEEF;
        drive_req(32'h208, 2'd0, d);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 1 || dc != 2 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL len0_lane got beats=%0d done_cyc=%0d err=%b want 1 2 0",
                     nb, dc, ev);
        end
    endtask

    task automatic test_len1_wrap();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        drive_req(32'h40, 2'd1, d);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 1 || dc != 2 || ev !== 1'b0) begin
            n_fail++;
            $display("FAIL len1 got beats=%0d done_cyc=%0d err=%b want 1 2 0", nb, dc, ev);
        end
        drive_req(32'hFFFF_FFE0, 2'd2, d);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 4 || dc != 5 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap got beats=%0d done_cyc=%0d err=%b want 4 5 0", nb, dc, ev);
        end
    endtask

    task automatic test_stall();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        drive_req(32'h1000, 2'd2, d);
        pump(0, 1, nb, nv, dc, ev);
        n_checks++;
        if (nb != 4 || dc != 11 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall got beats=%0d done_cyc=%0d err=%b want 4 11 0", nb, dc, ev);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_single_done got done=%b rdy=%b want 0 1", done, req_ready);
        end
        mem_wready = 1'b1;
    endtask

    task automatic test_errors();
        int nb, nv, dc;
        logic ev;
        drive_req(32'h104, 2'd1, '1);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (dc != 1 || ev !== 1'b1 || nv != 0 || nb != 0) begin
            n_fail++;
            $display("FAIL err_misalign got done_cyc=%0d err=%b valids=%0d want 1 1 0", dc, ev, nv);
        end
        drive_req(32'h0, 2'd3, '1);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (dc != 1 || ev !== 1'b1 || nv != 0 || nb != 0) begin
            n_fail++;
            $display("FAIL err_len3 got done_cyc=%0d err=%b valids=%0d want 1 1 0", dc, ev, nv);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        beat_t e;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        mem_wready = 1'b1;
        drive_req(32'h2000, 2'd2, d);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            e = exp_q.pop_front();
            n_checks++;
            if (mem_wvalid !== 1'b1 || mem_waddr !== e.a || mem_wdata !== e.d) begin
                n_fail++;
                $display("FAIL mid_beat c=%0d got v=%b a=%h want v=1 a=%h", c, mem_wvalid, mem_waddr, e.a);
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mem_wvalid !== 1'b0 || mem_waddr !== '0 || mem_wdata !== '0 ||
            mem_wstrb !== '0 || done !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b a=%h s=%h done=%b rdy=%b want all 0",
                     mem_wvalid, mem_waddr, mem_wstrb, done, req_ready);
        end
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || mem_wvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got done=%b v=%b want 0 0", c, done, mem_wvalid);
            end
        end
        reset = 1'b0;
        drive_req(32'h300, 2'd1, d);
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 1 || dc != 2 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset got beats=%0d done_cyc=%0d err=%b want 1 2 0", nb, dc, ev);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] d;
        int nb, nv, dc;
        logic ev;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        drive_req(32'h400, 2'd2, d);
        pump(1, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 4 || dc != 5 || ev !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first got beats=%0d done_cyc=%0d err=%b want 4 5 0", nb, dc, ev);
        end
        req_addr = 32'h800;
        req_len  = 2'd1;
        req_data = ~d;
        push_store(32'h800, 2'd1, ~d);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || mem_wvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got rdy=%b v=%b want 1 0", req_ready, mem_wvalid);
        end
        pump(0, 0, nb, nv, dc, ev);
        n_checks++;
        if (nb != 1 || dc != 2 || ev !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_second got beats=%0d done_cyc=%0d err=%b want 1 2 0", nb, dc, ev);
        end
    endtask

    initial begin
        test_reset();
        test_len2_burst();
        test_len0_lane();
        test_len1_wrap();
        test_stall();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
